// File: rtl/serial_adder.sv
// Bit-serial (chunk-serial) adder/subtractor: one CHUNK-wide slice reused for
// WIDTH/CHUNK cycles, with a start/busy/done handshake and carry/overflow flags.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             i,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             v
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cy;
  logic [KW-1:0]    k;

  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   sum;
  logic             last;

  // Operands shift right each cycle so the active chunk is always the low one;
  // on the last chunk its top bit is the original operand MSB.
  always_comb begin
    a_ch = a_r[CHUNK-1:0];
    b_ch = b_r[CHUNK-1:0];
    sum  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, cy};
    last = (k == KW'(NCHUNK - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      c     <= 1'b0;
      v     <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      cy    <= 1'b0;
      k     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            cy    <= sub ? ~i : i;
            k     <= '0;
            s     <= '0;
            c     <= 1'b0;
            v     <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_r <= a_r >> CHUNK;
          b_r <= b_r >> CHUNK;
          cy  <= sum[CHUNK];
          // Result chunks enter at the top and move down; after NCHUNK
          // cycles every chunk sits at its own position.
          s   <= WIDTH'({sum[CHUNK-1:0], s} >> CHUNK);
          k   <= k + 1'b1;
          if (last) begin
            c     <= sum[CHUNK];
            v     <= a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table on WIDTH=8/CHUNK=1,
// handshake and reset sequences, exhaustive WIDTH=4 for CHUNK=1,2,4.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic       start8, sub8, i8, busy8, done8, c8, v8;
  logic [7:0] a8, b8, s8;

  logic       start4, sub4, i4;
  logic [3:0] a4, b4;
  logic [3:0] s41, s42, s44;
  logic       busy41, done41, c41, v41;
  logic       busy42, done42, c42, v42;
  logic       busy44, done44, c44, v44;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8), .i(i8),
    .busy(busy8), .done(done8), .s(s8), .c(c8), .v(v8));
  serial_adder #(.WIDTH(4), .CHUNK(1)) u4_1 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .i(i4),
    .busy(busy41), .done(done41), .s(s41), .c(c41), .v(v41));
  serial_adder #(.WIDTH(4), .CHUNK(2)) u4_2 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .i(i4),
    .busy(busy42), .done(done42), .s(s42), .c(c42), .v(v42));
  serial_adder #(.WIDTH(4), .CHUNK(4)) u4_4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .i(i4),
    .busy(busy44), .done(done44), .s(s44), .c(c44), .v(v44));

  typedef struct {
    logic [7:0]  s;
    logic        c;
    logic        v;
    int unsigned edone;
  } exp_t;

  typedef struct {
    string      nm;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       i;
    logic [7:0] s;
    logic       c;
    logic       v;
  } vec_t;

  exp_t q8[$];
  exp_t q41[$];
  exp_t q42[$];
  exp_t q44[$];
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Independent reference: unsigned sum for s/c, signed arithmetic range for v.
  function automatic exp_t model(input int unsigned w, input logic sub,
                                 input int unsigned a, input int unsigned b, input logic i);
    exp_t        e;
    int unsigned m  = 1 << w;
    int          sa = (a >= m / 2) ? int'(a) - int'(m) : int'(a);
    int          sb = (b >= m / 2) ? int'(b) - int'(m) : int'(b);
    int unsigned u;
    int          r;
    if (!sub) begin
      u = a + b + 32'(i);
      r = sa + sb + int'(i);
    end else begin
      u = a + (m - 1 - b) + (i ? 0 : 1);
      r = sa - sb - int'(i);
    end
    e.s     = 8'(u % m);
    e.c     = (u >= m);
    e.v     = (r < -int'(m / 2)) || (r > int'(m / 2) - 1);
    e.edone = 0;
    return e;
  endfunction

  task automatic check_done(input string nm, input exp_t e, input logic [7:0] s,
                            input logic c, input logic v, input logic busy);
    chk({nm, ".s"}, 32'(s), 32'(e.s));
    chk({nm, ".c"}, 32'(c), 32'(e.c));
    chk({nm, ".v"}, 32'(v), 32'(e.v));
    chk({nm, ".latency"}, cyc, e.edone);
    chk({nm, ".busy_at_done"}, 32'(busy), 32'd0);
  endtask

  // Scoreboard: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done8 === 1'b1) begin
        chk("u8.pending", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) check_done("u8", q8.pop_front(), s8, c8, v8, busy8);
      end
      if (done41 === 1'b1) begin
        chk("u4_1.pending", 32'(q41.size() != 0), 32'd1);
        if (q41.size() != 0) check_done("u4_1", q41.pop_front(), {4'h0, s41}, c41, v41, busy41);
      end
      if (done42 === 1'b1) begin
        chk("u4_2.pending", 32'(q42.size() != 0), 32'd1);
        if (q42.size() != 0) check_done("u4_2", q42.pop_front(), {4'h0, s42}, c42, v42, busy42);
      end
      if (done44 === 1'b1) begin
        chk("u4_4.pending", 32'(q44.size() != 0), 32'd1);
        if (q44.size() != 0) check_done("u4_4", q44.pop_front(), {4'h0, s44}, c44, v44, busy44);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run8(input string nm, input logic sub, input logic [7:0] a,
                      input logic [7:0] b, input logic i, input exp_t e_in);
    exp_t e = e_in;
    sub8 = sub; a8 = a; b8 = b; i8 = i; start8 = 1'b1;
    e.edone = cyc + 1 + 8;
    q8.push_back(e);
    for (int k = 0; k < 8; k++) begin
      step();
      start8 = 1'b0;
      chk({nm, ".busy"}, 32'(busy8), 32'd1);
    end
    step();
    chk({nm, ".done"}, 32'(done8), 32'd1);
    step();
    chk({nm, ".done_pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{"add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{"add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{"add_80_80", 1'b0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
    tbl[3] = '{"sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[4] = '{"sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    tbl[5] = '{"sub_10_0f", 1'b1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0};

    rst_n = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; i8 = 1'b0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0; i4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.busy", 32'(busy8), 32'd0);
    chk("rst.done", 32'(done8), 32'd0);
    chk("rst.s", 32'(s8), 32'd0);
    chk("rst.c", 32'(c8), 32'd0);
    chk("rst.v", 32'(v8), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    for (int n = 0; n < 6; n++) begin
      e.s = tbl[n].s; e.c = tbl[n].c; e.v = tbl[n].v; e.edone = 0;
      run8(tbl[n].nm, tbl[n].sub, tbl[n].a, tbl[n].b, tbl[n].i, e);
    end

    // start mid-RUN with new operands must be ignored
    e = model(8, 1'b0, 32'h21, 32'h13, 1'b0);
    sub8 = 1'b0; a8 = 8'h21; b8 = 8'h13; i8 = 1'b0; start8 = 1'b1;
    e.edone = cyc + 1 + 8;
    q8.push_back(e);
    step();
    start8 = 1'b0;
    repeat (2) step();
    start8 = 1'b1; sub8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; i8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("midrun.busy", 32'(busy8), 32'd1);
    repeat (6) step();
    chk("midrun.drained", 32'(q8.size()), 32'd0);
    chk("midrun.idle", 32'(done8), 32'd0);

    // start held through DONE: back-to-back ops, done every NCHUNK+1 cycles
    for (int n = 0; n < 3; n++) begin
      a8 = 8'(8'h3C + n * 8'h51); b8 = 8'(8'hC5 + n * 8'h27); sub8 = n[0]; i8 = n[1];
      e = model(8, sub8, 32'(a8), 32'(b8), i8);
      e.edone = cyc + 1 + 8;
      q8.push_back(e);
      start8 = 1'b1;
      repeat (9) step();
    end
    start8 = 1'b0;
    step();
    chk("b2b.drained", 32'(q8.size()), 32'd0);

    // exhaustive WIDTH=4 on all three chunk sizes
    for (int ua = 0; ua < 16; ua++)
      for (int ub = 0; ub < 16; ub++)
        for (int us = 0; us < 2; us++)
          for (int ui = 0; ui < 2; ui++) begin
            a4 = 4'(ua); b4 = 4'(ub); sub4 = us[0]; i4 = ui[0]; start4 = 1'b1;
            e = model(4, sub4, 32'(ua), 32'(ub), i4);
            e.edone = cyc + 1 + 4; q41.push_back(e);
            e.edone = cyc + 1 + 2; q42.push_back(e);
            e.edone = cyc + 1 + 1; q44.push_back(e);
            step();
            start4 = 1'b0;
            repeat (4) step();
          end

    // reset during RUN chunk 3
    sub8 = 1'b0; a8 = 8'hFF; b8 = 8'h00; i8 = 1'b0; start8 = 1'b1;
    e = model(8, 1'b0, 32'hFF, 32'h00, 1'b0);
    e.edone = cyc + 1 + 8;
    q8.push_back(e);
    step();
    start8 = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    q8.delete();
    #1;
    chk("midrst.busy", 32'(busy8), 32'd0);
    chk("midrst.done", 32'(done8), 32'd0);
    chk("midrst.s", 32'(s8), 32'd0);
    chk("midrst.c", 32'(c8), 32'd0);
    chk("midrst.v", 32'(v8), 32'd0);
    chk("midrst.s4_1", 32'(s41), 32'd0);
    chk("midrst.s4_4", 32'(s44), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    e.s = 8'h46; e.c = 1'b0; e.v = 1'b0; e.edone = 0;
    run8("post_rst", 1'b0, 8'h12, 8'h34, 1'b0, e);

    step();
    chk("end.q8_empty", 32'(q8.size()), 32'd0);
    chk("end.q41_empty", 32'(q41.size()), 32'd0);
    chk("end.q42_empty", 32'(q42.size()), 32'd0);
    chk("end.q44_empty", 32'(q44.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
